// File: rtl/fpnew_opgroup_share_ctrl.sv
// Shares one FPnew opgroup block between NumReq requesters: round-robin issue with grant lock,
// an outstanding-operation credit limit, and return steering by the requester index carried in the tag.
module fpnew_opgroup_share_ctrl #(
   parameter int unsigned NumReq         = 2,
   parameter int unsigned PayloadWidth   = 128,
   parameter int unsigned Width          = 32,
   parameter int unsigned TagWidth       = 4,
   parameter int unsigned MaxOutstanding = 4,
   localparam int unsigned IdWidth       = (NumReq > 1) ? $clog2(NumReq) : 1,
   localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           flush_i,
   input  logic [NumReq-1:0]              req_valid_i,
   output logic [NumReq-1:0]              req_ready_o,
   input  logic [NumReq*PayloadWidth-1:0] req_data_i,
   input  logic [NumReq*TagWidth-1:0]     req_tag_i,
   output logic                           unit_in_valid_o,
   input  logic                           unit_in_ready_i,
   output logic [PayloadWidth-1:0]        unit_data_o,
   output logic [TagWidth+IdWidth-1:0]    unit_tag_o,
   input  logic                           unit_out_valid_i,
   output logic                           unit_out_ready_o,
   input  logic [Width-1:0]               unit_result_i,
   input  logic [4:0]                     unit_status_i,
   input  logic [TagWidth+IdWidth-1:0]    unit_tag_i,
   output logic [NumReq-1:0]              rsp_valid_o,
   input  logic [NumReq-1:0]              rsp_ready_i,
   output logic [Width-1:0]               rsp_result_o,
   output logic [4:0]                     rsp_status_o,
   output logic [TagWidth-1:0]            rsp_tag_o,
   output logic [CntWidth-1:0]            outstanding_o,
   output logic                           busy_o
);

   logic [IdWidth-1:0]  r_rrPtr;
   logic                r_lock;
   logic [IdWidth-1:0]  r_lockIdx;
   logic [CntWidth-1:0] r_cnt;

   logic [IdWidth-1:0]  w_rrWinner;
   logic                w_found;
   logic [IdWidth-1:0]  w_winner;
   logic [IdWidth-1:0]  w_retId;
   logic                w_canIssue;
   logic                w_issueHs;
   logic                w_retHs;

   // Modulo-NumReq increment; base and offset are both below NumReq so one subtraction suffices.
   function automatic logic [IdWidth-1:0] wrapInc(input logic [IdWidth-1:0] base,
                                                  input int unsigned off);
      int unsigned s;
      s = 32'(base) + off;
      if (s >= NumReq) s = s - NumReq;
      return IdWidth'(s);
   endfunction

   always_comb begin
      w_rrWinner = r_rrPtr;
      w_found    = 1'b0;
      for (int unsigned k = 0; k < NumReq; k++) begin
         if (!w_found && req_valid_i[wrapInc(r_rrPtr, k)]) begin
            w_rrWinner = wrapInc(r_rrPtr, k);
            w_found    = 1'b1;
         end
      end
   end

   // A stalled grant stays with its requester until the handshake so the payload never changes under valid.
   assign w_winner        = r_lock ? r_lockIdx : w_rrWinner;
   assign w_canIssue      = rst_ni & ~flush_i & (r_cnt < CntWidth'(MaxOutstanding));
   assign unit_in_valid_o = w_canIssue & req_valid_i[w_winner];
   assign unit_data_o     = req_data_i[32'(w_winner)*PayloadWidth +: PayloadWidth];
   assign unit_tag_o      = {w_winner, req_tag_i[32'(w_winner)*TagWidth +: TagWidth]};

   always_comb begin
      req_ready_o           = '0;
      req_ready_o[w_winner] = w_canIssue & unit_in_ready_i;
   end

   assign w_retId = unit_tag_i[TagWidth +: IdWidth];

   always_comb begin
      rsp_valid_o          = '0;
      rsp_valid_o[w_retId] = rst_ni & unit_out_valid_i & ~flush_i;
   end

   // During flush returns are accepted and dropped so the shared block drains.
   assign unit_out_ready_o = rst_ni & (rsp_ready_i[w_retId] | flush_i);
   assign rsp_result_o     = unit_result_i;
   assign rsp_status_o     = unit_status_i;
   assign rsp_tag_o        = unit_tag_i[TagWidth-1:0];

   assign w_issueHs     = unit_in_valid_o & unit_in_ready_i;
   assign w_retHs       = unit_out_valid_i & unit_out_ready_o & ~flush_i;
   assign outstanding_o = r_cnt;
   assign busy_o        = (r_cnt != '0) | unit_in_valid_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rrPtr   <= '0;
         r_lock    <= 1'b0;
         r_lockIdx <= '0;
         r_cnt     <= '0;
      end else if (flush_i) begin
         r_cnt  <= '0;
         r_lock <= 1'b0;
      end else begin
         if (w_issueHs && !w_retHs) begin
            r_cnt <= r_cnt + CntWidth'(1);
         end else if (w_retHs && !w_issueHs) begin
            r_cnt <= r_cnt - CntWidth'(1);
         end
         if (w_issueHs) begin
            r_lock  <= 1'b0;
            r_rrPtr <= wrapInc(w_winner, 1);
         end else if (unit_in_valid_o) begin
            r_lock    <= 1'b1;
            r_lockIdx <= w_winner;
         end
      end
   end

   a_retIdLegal : assert property (@(posedge clk_i) disable iff (!rst_ni)
      unit_out_valid_i |-> (32'(w_retId) < NumReq));
   a_noUnderflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
      w_retHs |-> (r_cnt != '0));

endmodule

// File: tb/tb_fpnew_opgroup_share_ctrl.sv
// Bench for fpnew_opgroup_share_ctrl: directed scenarios then random traffic, checked against
// a transaction-level model (in-flight count, grant owner, round-robin pointer).
module tb_fpnew_opgroup_share_ctrl;
   localparam int unsigned NREQ = 2;
   localparam int unsigned PW   = 128;
   localparam int unsigned W    = 32;
   localparam int unsigned TW   = 4;
   localparam int unsigned MAXO = 4;
   localparam int unsigned IDW  = 1;
   localparam int unsigned CW   = 3;

   logic                  clk_i = 1'b0;
   logic                  rst_ni;
   logic                  flush_i;
   logic [NREQ-1:0]       req_valid_i;
   logic [NREQ-1:0]       req_ready_o;
   logic [NREQ*PW-1:0]    req_data_i;
   logic [NREQ*TW-1:0]    req_tag_i;
   logic                  unit_in_valid_o;
   logic                  unit_in_ready_i;
   logic [PW-1:0]         unit_data_o;
   logic [TW+IDW-1:0]     unit_tag_o;
   logic                  unit_out_valid_i;
   logic                  unit_out_ready_o;
   logic [W-1:0]          unit_result_i;
   logic [4:0]            unit_status_i;
   logic [TW+IDW-1:0]     unit_tag_i;
   logic [NREQ-1:0]       rsp_valid_o;
   logic [NREQ-1:0]       rsp_ready_i;
   logic [W-1:0]          rsp_result_o;
   logic [4:0]            rsp_status_o;
   logic [TW-1:0]         rsp_tag_o;
   logic [CW-1:0]         outstanding_o;
   logic                  busy_o;

   fpnew_opgroup_share_ctrl #(
      .NumReq(NREQ), .PayloadWidth(PW), .Width(W), .TagWidth(TW), .MaxOutstanding(MAXO)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_data_i(req_data_i), .req_tag_i(req_tag_i),
      .unit_in_valid_o(unit_in_valid_o), .unit_in_ready_i(unit_in_ready_i),
      .unit_data_o(unit_data_o), .unit_tag_o(unit_tag_o),
      .unit_out_valid_i(unit_out_valid_i), .unit_out_ready_o(unit_out_ready_o),
      .unit_result_i(unit_result_i), .unit_status_i(unit_status_i), .unit_tag_i(unit_tag_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_result_o(rsp_result_o), .rsp_status_o(rsp_status_o), .rsp_tag_o(rsp_tag_o),
      .outstanding_o(outstanding_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   int            nVectors;
   int            nMiscompares;
   int            mCnt;
   int            mRrPtr;
   int            mLockIdx;
   bit            mLocked;
   logic [PW-1:0] reqData [NREQ];
   logic [TW-1:0] reqTag  [NREQ];
   int            expWinner;
   bit            expInValid;
   bit            expIssue;
   bit            expRet;
   bit            curFlush;
   logic [PW-1:0] heldData;

   function automatic logic [PW-1:0] rndData();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic checkOutput(input string name, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
      nVectors++;
      assert (obs === exp) else begin
         nMiscompares++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", name, obs, exp);
      end
   endtask

   task automatic checkResetOutputs(input string name);
      checkOutput({name, "_in_valid"},  128'(unit_in_valid_o),  128'(0));
      checkOutput({name, "_req_ready"}, 128'(req_ready_o),      128'(0));
      checkOutput({name, "_rsp_valid"}, 128'(rsp_valid_o),      128'(0));
      checkOutput({name, "_out_ready"}, 128'(unit_out_ready_o), 128'(0));
      checkOutput({name, "_cnt"},       128'(outstanding_o),    128'(0));
      checkOutput({name, "_busy"},      128'(busy_o),           128'(0));
   endtask

   // Drive one cycle of inputs at the falling edge, then check every output against the model.
   task automatic applyStimulus(input logic [1:0] valid, input logic inReady, input logic outValid,
                                input logic [4:0] retTag, input logic [1:0] rspReady, input logic flush);
      bit         canIssue;
      bit         found;
      bit         expOutReady;
      int         retId;
      logic [1:0] expReqReady;
      logic [1:0] expRspValid;
      logic [4:0] expTag;
      @(negedge clk_i);
      req_valid_i      = valid;
      unit_in_ready_i  = inReady;
      unit_out_valid_i = outValid;
      unit_tag_i       = retTag;
      rsp_ready_i      = rspReady;
      flush_i          = flush;
      unit_result_i    = $urandom;
      unit_status_i    = 5'($urandom);
      for (int i = 0; i < NREQ; i++) begin
         req_data_i[i*PW +: PW] = reqData[i];
         req_tag_i[i*TW +: TW]  = reqTag[i];
      end
      #1;
      if (mLocked) begin
         expWinner = mLockIdx;
      end else begin
         found     = 1'b0;
         expWinner = mRrPtr;
         for (int k = 0; k < NREQ; k++) begin
            if (!found && valid[(mRrPtr + k) % NREQ]) begin
               expWinner = (mRrPtr + k) % NREQ;
               found     = 1'b1;
            end
         end
      end
      canIssue    = (mCnt < MAXO) && !flush;
      expInValid  = canIssue && valid[expWinner];
      expReqReady = (canIssue && inReady) ? 2'(1 << expWinner) : 2'b00;
      expIssue    = expInValid && inReady;
      retId       = int'(retTag[4]);
      expRspValid = (outValid && !flush) ? 2'(1 << retId) : 2'b00;
      expOutReady = rspReady[retId] || flush;
      expRet      = outValid && expOutReady && !flush;
      curFlush    = flush;
      checkOutput("in_valid",  128'(unit_in_valid_o),  128'(expInValid));
      checkOutput("req_ready", 128'(req_ready_o),      128'(expReqReady));
      checkOutput("rsp_valid", 128'(rsp_valid_o),      128'(expRspValid));
      checkOutput("out_ready", 128'(unit_out_ready_o), 128'(expOutReady));
      checkOutput("count",     128'(outstanding_o),    128'(mCnt));
      checkOutput("busy",      128'(busy_o),           128'((mCnt != 0) || expInValid));
      if (expInValid) begin
         expTag = {IDW'(expWinner), reqTag[expWinner]};
         checkOutput("unit_data", unit_data_o,      reqData[expWinner]);
         checkOutput("unit_tag",  128'(unit_tag_o), 128'(expTag));
      end
      if (outValid && !flush) begin
         checkOutput("rsp_tag",    128'(rsp_tag_o),    128'(retTag[3:0]));
         checkOutput("rsp_result", 128'(rsp_result_o), 128'(unit_result_i));
         checkOutput("rsp_status", 128'(rsp_status_o), 128'(unit_status_i));
      end
   endtask

   task automatic endCycle();
      @(posedge clk_i);
      if (curFlush) begin
         mCnt    = 0;
         mLocked = 1'b0;
      end else begin
         mCnt = mCnt + int'(expIssue) - int'(expRet);
         if (expIssue) begin
            mLocked            = 1'b0;
            mRrPtr             = (expWinner + 1) % NREQ;
            reqData[expWinner] = rndData();
            reqTag[expWinner]  = TW'($urandom);
         end else if (expInValid) begin
            mLocked  = 1'b1;
            mLockIdx = expWinner;
         end
      end
   endtask

   task automatic step(input logic [1:0] valid, input logic inReady, input logic outValid,
                       input logic [4:0] retTag, input logic [1:0] rspReady, input logic flush);
      applyStimulus(valid, inReady, outValid, retTag, rspReady, flush);
      endCycle();
   endtask

   task automatic randomCycle();
      logic ov;
      ov = (mCnt > 0) && ($urandom_range(1, 0) == 1);
      step(2'($urandom), 1'($urandom_range(3, 0) != 0), ov, 5'($urandom), 2'($urandom),
           1'($urandom_range(15, 0) == 0));
   endtask

   initial begin
      nVectors = 0; nMiscompares = 0;
      mCnt = 0; mRrPtr = 0; mLockIdx = 0; mLocked = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         reqData[i] = rndData();
         reqTag[i]  = TW'($urandom);
         req_data_i[i*PW +: PW] = reqData[i];
         req_tag_i[i*TW +: TW]  = reqTag[i];
      end
      rst_ni = 1'b0; flush_i = 1'b0; req_valid_i = '1; unit_in_ready_i = 1'b1;
      unit_out_valid_i = 1'b1; unit_tag_i = '0; rsp_ready_i = '1;
      unit_result_i = '0; unit_status_i = '0;
      repeat (2) @(negedge clk_i);
      #1;
      checkResetOutputs("reset");
      @(negedge clk_i);
      req_valid_i = '0; unit_out_valid_i = 1'b0;
      rst_ni = 1'b1;

      // Credit limit: four issues fill the budget, the fifth waits for a return.
      repeat (4) step(2'b01, 1'b1, 1'b0, 5'h00, 2'b00, 1'b0);
      applyStimulus(2'b01, 1'b1, 1'b0, 5'h00, 2'b00, 1'b0);
      checkOutput("credit_full_cnt",    128'(outstanding_o),   128'(4));
      checkOutput("credit_block_valid", 128'(unit_in_valid_o), 128'(0));
      checkOutput("credit_block_ready", 128'(req_ready_o),     128'(0));
      endCycle();
      applyStimulus(2'b01, 1'b1, 1'b1, 5'h03, 2'b01, 1'b0);
      checkOutput("full_ret_ready",   128'(unit_out_ready_o), 128'(1));
      checkOutput("full_ret_noissue", 128'(unit_in_valid_o),  128'(0));
      endCycle();
      applyStimulus(2'b01, 1'b1, 1'b0, 5'h00, 2'b00, 1'b0);
      checkOutput("after_ret_cnt",   128'(outstanding_o),   128'(3));
      checkOutput("after_ret_issue", 128'(unit_in_valid_o), 128'(1));
      endCycle();
      repeat (2) step(2'b00, 1'b1, 1'b1, 5'h01, 2'b01, 1'b0);
      applyStimulus(2'b01, 1'b1, 1'b1, 5'h02, 2'b01, 1'b0);
      checkOutput("simul_issue",  128'(unit_in_valid_o),  128'(1));
      checkOutput("simul_return", 128'(unit_out_ready_o), 128'(1));
      endCycle();
      applyStimulus(2'b00, 1'b1, 1'b0, 5'h00, 2'b00, 1'b0);
      checkOutput("simul_cnt_kept", 128'(outstanding_o), 128'(2));
      endCycle();

      // Round-robin: last grant went to requester 0, so grants run 1,0,1,0,1.
      for (int k = 0; k < 5; k++) begin
         applyStimulus(2'b11, 1'b1, 1'b1, 5'h00, 2'b11, 1'b0);
         checkOutput("rr_grant", 128'(unit_tag_o[TW]), 128'((k + 1) % 2));
         endCycle();
      end

      // Lock: requester 1 stalls three cycles while requester 0 has round-robin priority.
      applyStimulus(2'b10, 1'b0, 1'b0, 5'h00, 2'b00, 1'b0);
      heldData = reqData[1];
      checkOutput("lock_first_grant", 128'(unit_tag_o[TW]), 128'(1));
      endCycle();
      repeat (2) begin
         applyStimulus(2'b11, 1'b0, 1'b0, 5'h00, 2'b00, 1'b0);
         checkOutput("lock_hold_grant", 128'(unit_tag_o[TW]), 128'(1));
         checkOutput("lock_hold_data",  unit_data_o,          heldData);
         endCycle();
      end
      applyStimulus(2'b11, 1'b1, 1'b0, 5'h00, 2'b00, 1'b0);
      checkOutput("lock_handshake", 128'(req_ready_o), 128'(2'b10));
      checkOutput("lock_hs_data",   unit_data_o,       heldData);
      endCycle();
      applyStimulus(2'b11, 1'b1, 1'b0, 5'h00, 2'b00, 1'b0);
      checkOutput("after_lock_grant", 128'(unit_tag_o[TW]), 128'(0));
      endCycle();

      // Return steering by the index bit of the returned tag.
      applyStimulus(2'b00, 1'b1, 1'b1, {1'b1, 4'hA}, 2'b01, 1'b0);
      checkOutput("steer_valid",     128'(rsp_valid_o),      128'(2'b10));
      checkOutput("steer_tag",       128'(rsp_tag_o),        128'(4'hA));
      checkOutput("steer_not_ready", 128'(unit_out_ready_o), 128'(0));
      endCycle();
      applyStimulus(2'b00, 1'b1, 1'b1, {1'b1, 4'hA}, 2'b11, 1'b0);
      checkOutput("steer_ready", 128'(unit_out_ready_o), 128'(1));
      endCycle();
      applyStimulus(2'b00, 1'b1, 1'b0, 5'h00, 2'b00, 1'b0);
      checkOutput("steer_cnt", 128'(outstanding_o), 128'(3));
      endCycle();

      // Flush with count 3, a held grant on requester 0, and a result waiting.
      step(2'b01, 1'b0, 1'b0, 5'h00, 2'b00, 1'b0);
      applyStimulus(2'b11, 1'b1, 1'b1, 5'h05, 2'b00, 1'b1);
      checkOutput("flush_rsp_valid", 128'(rsp_valid_o),      128'(0));
      checkOutput("flush_out_ready", 128'(unit_out_ready_o), 128'(1));
      checkOutput("flush_no_issue",  128'(unit_in_valid_o),  128'(0));
      endCycle();
      applyStimulus(2'b11, 1'b0, 1'b0, 5'h00, 2'b00, 1'b0);
      checkOutput("flush_cnt_clear",  128'(outstanding_o),   128'(0));
      checkOutput("flush_lock_clear", 128'(unit_tag_o[TW]),  128'(1));
      endCycle();

      for (int n = 0; n < 250; n++) randomCycle();

      // Asynchronous reset in the middle of traffic.
      step(2'b01, 1'b1, 1'b0, 5'h00, 2'b00, 1'b0);
      @(negedge clk_i);
      req_valid_i = '1; unit_in_ready_i = 1'b1; unit_out_valid_i = 1'b1;
      rsp_ready_i = '1; flush_i = 1'b0;
      #2 rst_ni = 1'b0;
      #1 checkResetOutputs("async_reset");
      @(negedge clk_i);
      #1 checkResetOutputs("reset_hold");
      req_valid_i = '0; unit_out_valid_i = 1'b0;
      rst_ni = 1'b1;
      mCnt = 0; mRrPtr = 0; mLockIdx = 0; mLocked = 1'b0;

      for (int n = 0; n < 250; n++) randomCycle();

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end
endmodule
